// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg : shared types and constants for the register-file write port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wb_state_t;

  // Priority pointer encoding; also the bit index of each requester in req/grant.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2 : two-input round-robin arbiter with a one-hot grant
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr_q == REQ_ALU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Pointer only moves when a contended grant completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= REQ_ALU;
    end else if (advance) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter : zero-fills the register file, then round-robin shares
// its write port between ALU and load writeback.   Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDRESS_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] a3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic                     init_done
);

  localparam logic [ADDRESS_WIDTH-1:0] C_ONE      = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] C_ADDR_MAX = '1;

  wb_state_t                state_q;
  logic [ADDRESS_WIDTH-1:0] clr_addr_q;

  logic       w_clear;
  logic       w_run;
  logic [1:0] w_req;
  logic [1:0] w_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= C_ONE;
    end else begin
      unique case (state_q)
        CLEAR: begin
          clr_addr_q <= clr_addr_q + C_ONE;
          if (clr_addr_q == C_ADDR_MAX) begin
            state_q <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are squashed while rst is high so a mid-run reset acknowledges nothing.
  assign w_clear   = (state_q == CLEAR) && !rst;
  assign w_run     = (state_q == RUN) && !rst;
  assign w_req     = {mem_valid, alu_valid} & {2{w_run}};
  assign alu_ready = w_grant[REQ_ALU];
  assign mem_ready = w_grant[REQ_MEM];
  assign init_done = w_run;

  rr_arbiter2 u_rr_arbiter2 (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (&w_req),
    .grant   (w_grant)
  );

  always_comb begin
    we3 = 1'b0;
    a3  = '0;
    wd3 = '0;
    if (w_clear) begin
      we3 = 1'b1;
      a3  = clr_addr_q;
    end else if (w_grant[REQ_ALU]) begin
      we3 = |alu_addr;
      a3  = alu_addr;
      wd3 = alu_data;
    end else if (w_grant[REQ_MEM]) begin
      we3 = |mem_addr;
      a3  = mem_addr;
      wd3 = mem_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter : randomized bench against a behavioural write-port model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_addr  = '0;
  logic [DW-1:0] alu_data  = '0;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_addr  = '0;
  logic [DW-1:0] mem_data  = '0;
  logic          alu_ready, mem_ready, we3, init_done;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .init_done (init_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // rf: register file built from what the DUT writes; exp_rf: what the model says it should hold.
  logic [DW-1:0] rf     [NREG];
  logic [DW-1:0] exp_rf [NREG];

  bit m_run = 1'b0;
  int m_clr = 1;
  bit m_pri = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at negedge, then advance model and register file after posedge.
  task automatic step();
    logic          e_we, e_ar, e_mr, e_init;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd;
    logic          s_we;
    logic [AW-1:0] s_a;
    logic [DW-1:0] s_wd;
    int            g;
    @(negedge clk);
    g = -1;
    e_we = 1'b0; e_ar = 1'b0; e_mr = 1'b0; e_init = 1'b0;
    e_a = '0; e_wd = '0;
    if (!rst) begin
      if (!m_run) begin
        e_we = 1'b1;
        e_a  = m_clr[AW-1:0];
      end else begin
        e_init = 1'b1;
        if (alu_valid && mem_valid) g = int'(m_pri);
        else if (alu_valid)         g = 0;
        else if (mem_valid)         g = 1;
        if (g == 0) begin
          e_ar = 1'b1; e_a = alu_addr; e_wd = alu_data; e_we = (alu_addr != 0);
        end else if (g == 1) begin
          e_mr = 1'b1; e_a = mem_addr; e_wd = mem_data; e_we = (mem_addr != 0);
        end
      end
    end
    check_eq("we3",       32'(we3),       32'(e_we));
    check_eq("a3",        32'(a3),        32'(e_a));
    check_eq("wd3",       wd3,            e_wd);
    check_eq("alu_ready", 32'(alu_ready), 32'(e_ar));
    check_eq("mem_ready", 32'(mem_ready), 32'(e_mr));
    check_eq("init_done", 32'(init_done), 32'(e_init));
    s_we = we3; s_a = a3; s_wd = wd3;
    @(posedge clk);
    #1;
    if (s_we === 1'b1) rf[s_a] = s_wd;
    if (rst) begin
      m_run = 1'b0; m_clr = 1; m_pri = 1'b0;
    end else if (!m_run) begin
      exp_rf[m_clr] = '0;
      if (m_clr == NREG - 1) m_run = 1'b1;
      else                   m_clr++;
    end else begin
      if (g >= 0 && alu_valid && mem_valid) m_pri = ~m_pri;
      if (g == 0) begin
        if (alu_addr != 0) exp_rf[alu_addr] = alu_data;
        alu_valid = 1'b0;
      end else if (g == 1) begin
        if (mem_addr != 0) exp_rf[mem_addr] = mem_data;
        mem_valid = 1'b0;
      end
    end
  endtask

  task automatic gen();
    if (!alu_valid && ($urandom_range(1, 0) == 1)) begin
      alu_valid = 1'b1;
      alu_addr  = AW'($urandom_range(NREG - 1, 0));
      alu_data  = $urandom;
    end
    if (!mem_valid && ($urandom_range(1, 0) == 1)) begin
      mem_valid = 1'b1;
      mem_addr  = AW'($urandom_range(NREG - 1, 0));
      mem_data  = $urandom;
    end
  endtask

  initial begin
    int budget;
    for (int i = 0; i < NREG; i++) begin
      rf[i]     = (i == 0) ? '0 : (32'hA5A5_0000 | 32'(i));
      exp_rf[i] = rf[i];
    end
    // Both requesters pending through reset and the whole zero-fill.
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h22;
    repeat (3) step();
    rst = 1'b0;
    repeat (33) step();
    check_eq("rd_x3", rf[3], 32'h11);
    check_eq("rd_x4", rf[4], 32'h22);
    check_eq("rd_x31_cleared", rf[31], 32'h0);

    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    check_eq("rd_x5", rf[5], 32'hDEADBEEF);

    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h33;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h44;
    repeat (3) step();

    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hFFFFFFFF;
    step();
    check_eq("rd_x0", rf[0], 32'h0);

    for (int i = 0; i < 300; i++) begin
      gen();
      if (i == 150) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    budget = 0;
    while ((alu_valid || mem_valid) && budget < 10) begin
      step();
      budget++;
    end
    check_eq("drain", 32'(alu_valid || mem_valid), 32'h0);
    step();
    for (int i = 0; i < NREG; i++) begin
      check_eq($sformatf("rf_x%0d", i), rf[i], exp_rf[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
